// File: rtl/rf_seq_pkg.sv
// Shared widths, op codes and FSM state encoding for the register-file sequencer.
package rf_seq_pkg;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_MOV = 3'd5;
  localparam logic [2:0] OP_LDI = 3'd6;
  localparam logic [2:0] OP_NOP = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WRITE
  } state_e;

endpackage

// File: rtl/rf_seq_alu.sv
// Combinational datapath: operands and immediate to a DW-bit wrap-around result.
module rf_seq_alu
  import rf_seq_pkg::*;
(
  input  logic [2:0]    i_op,
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  input  logic [DW-1:0] i_imm,
  output logic [DW-1:0] o_result
);

  always_comb begin
    o_result = '0;
    unique case (i_op)
      OP_ADD: o_result = i_a + i_b;
      OP_SUB: o_result = i_a - i_b;
      OP_AND: o_result = i_a & i_b;
      OP_OR:  o_result = i_a | i_b;
      OP_XOR: o_result = i_a ^ i_b;
      OP_MOV: o_result = i_a;
      OP_LDI: o_result = i_imm;
      // NOP reports the rs1 operand it read.
      OP_NOP: o_result = i_a;
    endcase
  end

endmodule

// File: rtl/rf_sequencer.sv
// Request-driven sequencer that reads two operands from the register file,
// computes a result and writes it back, one request at a time.
module rf_sequencer
  import rf_seq_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_req_valid,
  output logic          o_req_ready,
  input  logic [2:0]    i_req_op,
  input  logic [AW-1:0] i_req_rd,
  input  logic [AW-1:0] i_req_rs1,
  input  logic [AW-1:0] i_req_rs2,
  input  logic [DW-1:0] i_req_imm,
  output logic          o_rf_en,
  output logic          o_rf_rd,
  output logic          o_rf_wr,
  output logic [AW-1:0] o_rf_so1,
  output logic [AW-1:0] o_rf_so2,
  output logic [AW-1:0] o_rf_si1,
  output logic [DW-1:0] o_rf_i1,
  input  logic [DW-1:0] i_rf_o1,
  input  logic [DW-1:0] i_rf_o2,
  output logic          o_done,
  output logic [DW-1:0] o_result
);

  state_e        r_state, w_state_d;
  logic          r_ready;
  logic [2:0]    r_op;
  logic [AW-1:0] r_rd;
  logic [DW-1:0] r_imm;
  logic [AW-1:0] r_so1, r_so2, r_si1;
  logic [DW-1:0] r_i1, r_result;
  logic [DW-1:0] w_alu;
  logic          w_accept, w_run, w_nop_done;

  rf_seq_alu u_alu (
    .i_op     (r_op),
    .i_a      (i_rf_o1),
    .i_b      (i_rf_o2),
    .i_imm    (r_imm),
    .o_result (w_alu)
  );

  always_comb begin
    w_state_d = r_state;
    w_accept  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_req_valid && r_ready) begin
          w_accept  = 1'b1;
          w_state_d = (i_req_op == OP_LDI) ? S_WRITE : S_READ;
        end
      end
      S_READ:  w_state_d = S_EXEC;
      S_EXEC:  w_state_d = (r_op == OP_NOP) ? S_IDLE : S_WRITE;
      S_WRITE: w_state_d = S_IDLE;
      default: w_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_ready  <= 1'b0;
      r_op     <= OP_ADD;
      r_rd     <= '0;
      r_imm    <= '0;
      r_so1    <= '0;
      r_so2    <= '0;
      r_si1    <= '0;
      r_i1     <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_state_d;
      r_ready <= (w_state_d == S_IDLE);
      if (w_accept) begin
        r_op  <= i_req_op;
        r_rd  <= i_req_rd;
        r_imm <= i_req_imm;
        // LDI skips the read phase, so write select/data are loaded right away.
        if (i_req_op == OP_LDI) begin
          r_si1    <= i_req_rd;
          r_i1     <= i_req_imm;
          r_result <= i_req_imm;
        end else begin
          r_so1 <= i_req_rs1;
          r_so2 <= i_req_rs2;
        end
      end
      if (r_state == S_EXEC) begin
        r_result <= w_alu;
        if (r_op != OP_NOP) begin
          r_si1 <= r_rd;
          r_i1  <= w_alu;
        end
      end
    end
  end

  // Reset kills strobes immediately so an in-flight write never lands.
  assign w_run      = !i_rst;
  assign w_nop_done = w_run && (r_state == S_EXEC) && (r_op == OP_NOP);

  assign o_req_ready = r_ready;
  assign o_rf_en     = w_run && ((r_state == S_READ) || (r_state == S_WRITE));
  assign o_rf_rd     = w_run && (r_state == S_READ);
  assign o_rf_wr     = w_run && (r_state == S_WRITE);
  assign o_rf_so1    = r_so1;
  assign o_rf_so2    = r_so2;
  assign o_rf_si1    = r_si1;
  assign o_rf_i1     = r_i1;
  assign o_done      = (w_run && (r_state == S_WRITE)) || w_nop_done;
  assign o_result    = w_nop_done ? w_alu : r_result;

endmodule

// File: tb/tb_rf_sequencer.sv
// Scoreboard bench for rf_sequencer with a behavioural 16x32 regfile attached.
module tb_rf_sequencer;
  import rf_seq_pkg::*;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [2:0]    req_op = 3'd0;
  logic [AW-1:0] req_rd = '0, req_rs1 = '0, req_rs2 = '0;
  logic [DW-1:0] req_imm = '0;
  logic          rf_en, rf_rd, rf_wr, done;
  logic [AW-1:0] rf_so1, rf_so2, rf_si1;
  logic [DW-1:0] rf_i1, result;
  logic [DW-1:0] rf_o1, rf_o2;
  logic [DW-1:0] mem [16];

  typedef struct {
    logic [DW-1:0] res;
    int            lat;
    int            acc;
    string         name;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_cnt = 0;

  localparam logic [DW-1:0] VA = 32'habcd_efab;
  localparam logic [DW-1:0] VB = 32'h0123_4567;

  rf_sequencer dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_op    (req_op),
    .i_req_rd    (req_rd),
    .i_req_rs1   (req_rs1),
    .i_req_rs2   (req_rs2),
    .i_req_imm   (req_imm),
    .o_rf_en     (rf_en),
    .o_rf_rd     (rf_rd),
    .o_rf_wr     (rf_wr),
    .o_rf_so1    (rf_so1),
    .o_rf_so2    (rf_so2),
    .o_rf_si1    (rf_si1),
    .o_rf_i1     (rf_i1),
    .i_rf_o1     (rf_o1),
    .i_rf_o2     (rf_o2),
    .o_done      (done),
    .o_result    (result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Regfile model: read data registered on RD edge, write stored on WR edge.
  always @(posedge clk) begin
    if (rf_en && rf_rd) begin
      rf_o1 <= mem[rf_so1];
      rf_o2 <= mem[rf_so2];
    end
    if (rf_en && rf_wr) mem[rf_si1] <= rf_i1;
  end

  // Monitor: pops an expectation on every done pulse.
  always @(negedge clk) begin
    exp_t e;
    int lat;
    if (rf_wr) wr_cnt++;
    if (rf_rd && rf_wr) begin
      checks++;
      errors++;
      $display("FAIL rd_wr_overlap rd=%b wr=%b required not both high", rf_rd, rf_wr);
    end
    if (done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done result=%h required no done", result);
      end else begin
        e = q.pop_front();
        lat = cyc - e.acc + 1;
        checks++;
        if (result !== e.res) begin
          errors++;
          $display("FAIL %s result got=%h exp=%h", e.name, result, e.res);
        end
        checks++;
        if (lat != e.lat) begin
          errors++;
          $display("FAIL %s latency got=%0d exp=%0d", e.name, lat, e.lat);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic issue(input string name, input logic [2:0] op, input logic [AW-1:0] rd,
                       input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                       input logic [DW-1:0] imm, input logic [DW-1:0] exp_res,
                       input int exp_lat, input bit push);
    exp_t e;
    bit   ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s ready_timeout ready=%b required 1", name, req_ready);
      return;
    end
    req_valid = 1'b1;
    req_op    = op;
    req_rd    = rd;
    req_rs1   = rs1;
    req_rs2   = rs2;
    req_imm   = imm;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (push) begin
      e.res  = exp_res;
      e.lat  = exp_lat;
      e.acc  = cyc;
      e.name = name;
      q.push_back(e);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending=%0d required 0", q.size());
      q.delete();
    end
  endtask

  task automatic check_all_zero(input string name);
    check(name, {rf_en, rf_rd, rf_wr, done, req_ready, rf_so1, rf_so2, rf_si1}, '0);
    check({name, "_data"}, {rf_i1, result}, '0);
  endtask

  initial begin
    int wr_before;
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_reset", {63'd0, req_ready}, 64'd1);

    issue("ldi_r0", OP_LDI, 4'd0, 4'd0, 4'd0, VA, VA, 1, 1'b1);
    issue("mov_r2", OP_MOV, 4'd2, 4'd0, 4'd0, '0, VA, 3, 1'b1);
    issue("ldi_r1", OP_LDI, 4'd1, 4'd0, 4'd0, VB, VB, 1, 1'b1);
    issue("add_r3", OP_ADD, 4'd3, 4'd0, 4'd1, '0, VA + VB, 3, 1'b1);
    issue("mov_r3", OP_MOV, 4'd9, 4'd3, 4'd0, '0, VA + VB, 3, 1'b1);
    issue("ldi_r4", OP_LDI, 4'd4, 4'd0, 4'd0, 32'd0, 32'd0, 1, 1'b1);
    issue("ldi_r5", OP_LDI, 4'd5, 4'd0, 4'd0, 32'd1, 32'd1, 1, 1'b1);
    issue("sub_wrap", OP_SUB, 4'd6, 4'd4, 4'd5, '0, 32'hffff_ffff, 3, 1'b1);
    issue("and_r11", OP_AND, 4'd11, 4'd0, 4'd3, '0, VA & (VA + VB), 3, 1'b1);
    issue("or_r12", OP_OR, 4'd12, 4'd0, 4'd1, '0, VA | VB, 3, 1'b1);
    issue("xor_self", OP_XOR, 4'd1, 4'd1, 4'd1, '0, 32'd0, 3, 1'b1);
    issue("mov_r1", OP_MOV, 4'd10, 4'd1, 4'd0, '0, 32'd0, 3, 1'b1);
    drain();

    wr_before = wr_cnt;
    issue("nop", OP_NOP, 4'd0, 4'd0, 4'd1, 32'h5555_5555, VA, 2, 1'b1);
    drain();
    repeat (2) @(negedge clk);
    check("nop_no_write", 64'(wr_cnt - wr_before), 64'd0);
    check("nop_r0_r1", {mem[0], mem[1]}, {VA, 32'd0});

    // ADD into r6 aborted by reset during its EXEC cycle.
    wr_before = wr_cnt;
    issue("rst_add", OP_ADD, 4'd6, 4'd0, 4'd12, '0, '0, 0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("rst_exec");
    @(negedge clk);
    rst = 1'b0;
    check("rst_no_write", 64'(wr_cnt - wr_before), 64'd0);
    @(posedge clk);
    #1;
    check("ready_after_rst", {63'd0, req_ready}, 64'd1);
    issue("mov_r6", OP_MOV, 4'd8, 4'd6, 4'd0, '0, 32'hffff_ffff, 3, 1'b1);
    drain();
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time_limit reached required finish");
    $fatal(1, "watchdog");
  end

endmodule
